mem_tbus_arbiter: RTL and testbench

- Parametrised N-channel arbiter merging memory-side requesters onto the single trinity bus (tbus) toward dcache.
- Requesters are load units and store queue drain ports.
- Successor to the fixed load/SQ pair wiring: channel count, widths and arbitration mode are configurable; per-channel flush/kill of in-flight operations is supported.
- Exactly one tbus operation outstanding at a time.

---
 rtl/mem_tbus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_tbus_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_tbus_arbiter.sv
// mem_tbus_arbiter: merges NUM_CH memory-side requesters (load units, store
// queue drain ports) onto the single tbus toward dcache, one operation
// outstanding at a time, with per-channel flush of pending/in-flight ops.
// Build option MEM_TBUS_ARB_STRICT_PRIO_EN: fixed priority (lowest channel
// wins) instead of round-robin.
module mem_tbus_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = 64,
    parameter int OPT_W  = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          ch_index_valid,
    output logic [NUM_CH-1:0]          ch_index_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_index,
    input  logic [NUM_CH*DATA_W-1:0]   ch_write_data,
    input  logic [NUM_CH*MASK_W-1:0]   ch_write_mask,
    input  logic [NUM_CH*OPT_W-1:0]    ch_operation_type,
    input  logic [NUM_CH-1:0]          ch_flush_valid,
    output logic [NUM_CH-1:0]          ch_operation_done,
    output logic [DATA_W-1:0]          ch_read_data,
    output logic                       tbus_index_valid,
    input  logic                       tbus_index_ready,
    output logic [ADDR_W-1:0]          tbus_index,
    output logic [DATA_W-1:0]          tbus_write_data,
    output logic [MASK_W-1:0]          tbus_write_mask,
    output logic [OPT_W-1:0]           tbus_operation_type,
    input  logic [DATA_W-1:0]          tbus_read_data,
    input  logic                       tbus_operation_done,
    output logic                       tbus_flush_valid,
    output logic [CH_W-1:0]            grant_id
);

    localparam int unsigned NCH = NUM_CH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CH_W-1:0]     owner;
    logic [NUM_CH-1:0]   eligible;
    logic [CH_W-1:0]     pick;
    logic                pick_vld;
    logic                owner_flush;
    logic                accept;
    logic                flush_fire;
    logic                done_fire;

    // A flushing channel may not win arbitration in the same cycle.
    assign eligible    = ch_index_valid & ~ch_flush_valid;
    assign owner_flush = ch_flush_valid[owner];

`ifdef MEM_TBUS_ARB_STRICT_PRIO_EN
    // Fixed priority: lowest eligible channel index wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!pick_vld && eligible[i]) begin
                pick     = CH_W'(i);
                pick_vld = 1'b1;
            end
        end
    end
`else
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] rr_nxt;
    logic [CH_W-1:0] cand;
    int unsigned     idx;

    // Round-robin: first eligible channel at or after rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx  = (32'(rr_ptr) + i) % NCH;
            cand = CH_W'(idx);
            if (!pick_vld && eligible[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign rr_nxt = (32'(pick) == NCH - 1) ? '0 : pick + 1'b1;

    // Pointer moves just past the channel that was accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_nxt;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and combinational handshake/event decode.
    always_comb begin
        state_nxt        = state;
        ch_index_ready   = '0;
        tbus_index_valid = 1'b0;
        accept           = 1'b0;
        flush_fire       = 1'b0;
        done_fire        = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    ch_index_ready[pick] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = REQ;
                end
            end
            REQ: begin
                tbus_index_valid = 1'b1;
                // A handshake coinciding with flush is still accepted
                // downstream, so its completion must be drained.
                if (tbus_index_ready) begin
                    state_nxt  = owner_flush ? DRAIN : WAIT;
                    flush_fire = owner_flush;
                end else if (owner_flush) begin
                    state_nxt  = IDLE;
                    flush_fire = 1'b1;
                end
            end
            WAIT: begin
                if (tbus_operation_done) begin
                    state_nxt = IDLE;
                    done_fire = !owner_flush;
                end else if (owner_flush) begin
                    state_nxt  = DRAIN;
                    flush_fire = 1'b1;
                end
            end
            DRAIN: begin
                if (tbus_operation_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload capture on accept, registered completion/flush pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner               <= '0;
            tbus_index          <= '0;
            tbus_write_data     <= '0;
            tbus_write_mask     <= '0;
            tbus_operation_type <= '0;
            ch_read_data        <= '0;
            ch_operation_done   <= '0;
            tbus_flush_valid    <= 1'b0;
        end else begin
            tbus_flush_valid  <= flush_fire;
            ch_operation_done <= '0;
            if (done_fire) begin
                ch_operation_done[owner] <= 1'b1;
                ch_read_data             <= tbus_read_data;
            end
            if (accept) begin
                owner               <= pick;
                tbus_index          <= ch_index[32'(pick)*ADDR_W +: ADDR_W];
                tbus_write_data     <= ch_write_data[32'(pick)*DATA_W +: DATA_W];
                tbus_write_mask     <= ch_write_mask[32'(pick)*MASK_W +: MASK_W];
                tbus_operation_type <= ch_operation_type[32'(pick)*OPT_W +: OPT_W];
            end
        end
    end

    assign grant_id = owner;

endmodule

// File: tb/tb_mem_tbus_arbiter.sv
// Testbench for mem_tbus_arbiter: a 2-channel and a 4-channel instance,
// directed stimulus pushes expected events (with expected cycle) into
// queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mem_tbus_arbiter;

`ifdef MEM_TBUS_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    typedef struct {
        int          at;
        logic [7:0]  vec;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] m;
    } ev_t;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // 2-channel instance signals
    logic [1:0]   c2_valid, c2_ready, c2_flush, c2_done;
    logic [127:0] c2_index, c2_wdata, c2_mask;
    logic [3:0]   c2_op;
    logic [63:0]  c2_rdata;
    logic         t2_valid, t2_ready, t2_done, t2_fvalid;
    logic [63:0]  t2_index, t2_wdata, t2_mask, t2_rdata;
    logic [1:0]   t2_op;
    logic [0:0]   gid2;

    // 4-channel instance signals
    logic [3:0]   c4_valid, c4_ready, c4_flush, c4_done;
    logic [63:0]  c4_index, c4_wdata;
    logic [7:0]   c4_mask, c4_op;
    logic [15:0]  c4_rdata;
    logic         t4_valid, t4_ready, t4_done, t4_fvalid;
    logic [15:0]  t4_index, t4_wdata, t4_rdata;
    logic [1:0]   t4_mask, t4_op;
    logic [1:0]   gid4;

    ev_t g2_q[$], d2_q[$], f2_q[$], t2_q[$], g4_q[$], d4_q[$];
    ev_t me;

    mem_tbus_arbiter #(.NUM_CH(2), .ADDR_W(64), .DATA_W(64), .MASK_W(64), .OPT_W(2)) u2 (
        .clock(clock), .reset_n(reset_n),
        .ch_index_valid(c2_valid), .ch_index_ready(c2_ready),
        .ch_index(c2_index), .ch_write_data(c2_wdata), .ch_write_mask(c2_mask),
        .ch_operation_type(c2_op), .ch_flush_valid(c2_flush),
        .ch_operation_done(c2_done), .ch_read_data(c2_rdata),
        .tbus_index_valid(t2_valid), .tbus_index_ready(t2_ready),
        .tbus_index(t2_index), .tbus_write_data(t2_wdata), .tbus_write_mask(t2_mask),
        .tbus_operation_type(t2_op), .tbus_read_data(t2_rdata),
        .tbus_operation_done(t2_done), .tbus_flush_valid(t2_fvalid), .grant_id(gid2)
    );

    mem_tbus_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .MASK_W(2), .OPT_W(2)) u4 (
        .clock(clock), .reset_n(reset_n),
        .ch_index_valid(c4_valid), .ch_index_ready(c4_ready),
        .ch_index(c4_index), .ch_write_data(c4_wdata), .ch_write_mask(c4_mask),
        .ch_operation_type(c4_op), .ch_flush_valid(c4_flush),
        .ch_operation_done(c4_done), .ch_read_data(c4_rdata),
        .tbus_index_valid(t4_valid), .tbus_index_ready(t4_ready),
        .tbus_index(t4_index), .tbus_write_data(t4_wdata), .tbus_write_mask(t4_mask),
        .tbus_operation_type(t4_op), .tbus_read_data(t4_rdata),
        .tbus_operation_done(t4_done), .tbus_flush_valid(t4_fvalid), .grant_id(gid4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s unexpected event got=%h expected=none (cycle %0d)", nm, got, cyc);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set2(input int ch, input logic [63:0] idx, input logic [63:0] wd,
                        input logic [63:0] mk, input logic [1:0] op);
        c2_index[ch*64 +: 64] = idx;
        c2_wdata[ch*64 +: 64] = wd;
        c2_mask[ch*64 +: 64]  = mk;
        c2_op[ch*2 +: 2]      = op;
    endtask

    task automatic exp_ev(input int kind, input int at, input logic [7:0] v,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
        ev_t e;
        e = '{at: at, vec: v, a: a, b: b, m: m};
        case (kind)
            0: g2_q.push_back(e);
            1: d2_q.push_back(e);
            2: f2_q.push_back(e);
            3: t2_q.push_back(e);
            4: g4_q.push_back(e);
            default: d4_q.push_back(e);
        endcase
    endtask

    // Monitor: compare every presented DUT event against its queue.
    always @(negedge clock) begin
        if (mon_en) begin
            if (c2_ready != '0) begin
                if (g2_q.size() == 0) unexp("grant2", 64'(c2_ready));
                else begin
                    me = g2_q.pop_front();
                    chk("grant2_cycle", 64'(cyc), 64'(me.at));
                    chk("grant2_ready", 64'(c2_ready), 64'(me.vec));
                end
            end
            if (t2_valid && t2_ready) begin
                if (t2_q.size() == 0) unexp("treq2", t2_index);
                else begin
                    me = t2_q.pop_front();
                    chk("treq2_cycle", 64'(cyc), 64'(me.at));
                    chk("treq2_op", 64'(t2_op), 64'(me.vec));
                    chk("treq2_index", t2_index, me.a);
                    chk("treq2_wdata", t2_wdata, me.b);
                    chk("treq2_mask", t2_mask, me.m);
                end
            end
            if (t2_fvalid) begin
                if (f2_q.size() == 0) unexp("flush2", 64'(t2_fvalid));
                else begin
                    me = f2_q.pop_front();
                    chk("flush2_cycle", 64'(cyc), 64'(me.at));
                end
            end
            if (c2_done != '0) begin
                if (d2_q.size() == 0) unexp("done2", 64'(c2_done));
                else begin
                    me = d2_q.pop_front();
                    chk("done2_cycle", 64'(cyc), 64'(me.at));
                    chk("done2_vec", 64'(c2_done), 64'(me.vec));
                    chk("done2_rdata", c2_rdata, me.a);
                    chk("done2_grant_id", 64'(gid2), me.b);
                end
            end
            if (c4_ready != '0) begin
                if (g4_q.size() == 0) unexp("grant4", 64'(c4_ready));
                else begin
                    me = g4_q.pop_front();
                    chk("grant4_cycle", 64'(cyc), 64'(me.at));
                    chk("grant4_ready", 64'(c4_ready), 64'(me.vec));
                end
            end
            if (c4_done != '0) begin
                if (d4_q.size() == 0) unexp("done4", 64'(c4_done));
                else begin
                    me = d4_q.pop_front();
                    chk("done4_cycle", 64'(cyc), 64'(me.at));
                    chk("done4_vec", 64'(c4_done), 64'(me.vec));
                    chk("done4_rdata", 64'(c4_rdata), me.a);
                    chk("done4_grant_id", 64'(gid4), me.b);
                end
            end
        end
    end

    initial begin
        int base;
        int ch;
        int first;
        logic [63:0] ix, wd, mk;
        logic [1:0]  op;

        c2_valid = '0; c2_flush = '0; c2_index = '0; c2_wdata = '0; c2_mask = '0; c2_op = '0;
        t2_ready = 1'b0; t2_done = 1'b0; t2_rdata = '0;
        c4_valid = '0; c4_flush = '0; c4_index = '0; c4_wdata = '0; c4_mask = '0; c4_op = '0;
        t4_ready = 1'b0; t4_done = 1'b0; t4_rdata = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) tick;

        // Reset values
        chk("rst_ready2", 64'(c2_ready), 64'd0);
        chk("rst_done2", 64'(c2_done), 64'd0);
        chk("rst_rdata2", c2_rdata, 64'd0);
        chk("rst_tvalid2", 64'(t2_valid), 64'd0);
        chk("rst_tindex2", t2_index, 64'd0);
        chk("rst_twdata2", t2_wdata, 64'd0);
        chk("rst_tmask2", t2_mask, 64'd0);
        chk("rst_top2", 64'(t2_op), 64'd0);
        chk("rst_tflush2", 64'(t2_fvalid), 64'd0);
        chk("rst_gid2", 64'(gid2), 64'd0);
        chk("rst_tvalid4", 64'(t4_valid), 64'd0);
        chk("rst_gid4", 64'(gid4), 64'd0);

        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick;

        // Single load on ch1, downstream ready at once, done 3 cycles later
        set2(1, 64'h8000_0040, 64'h0, 64'h0, 2'd0);
        c2_valid = 2'b10;
        t2_ready = 1'b1;
        exp_ev(0, cyc, 8'b10, '0, '0, '0);
        exp_ev(3, cyc + 1, 8'd0, 64'h8000_0040, 64'h0, 64'h0);
        tick; c2_valid = '0;
        tick; t2_ready = 1'b0;
        tick;
        tick; t2_done = 1'b1; t2_rdata = 64'hDEAD_BEEF;
        exp_ev(1, cyc + 1, 8'b10, 64'hDEAD_BEEF, 64'd1, '0);
        tick; t2_done = 1'b0; t2_rdata = '0;
        tick;

        // Both channels continuously valid, immediate ready/done
        set2(0, 64'h1000, 64'hA0A0, 64'h0F, 2'd1);
        set2(1, 64'h2000, 64'hB0B0, 64'hF0, 2'd2);
        c2_valid = 2'b11; t2_ready = 1'b1; t2_done = 1'b1; t2_rdata = 64'hCAFE;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            ch = STRICT ? 0 : (k % 2);
            ix = (ch == 0) ? 64'h1000 : 64'h2000;
            wd = (ch == 0) ? 64'hA0A0 : 64'hB0B0;
            mk = (ch == 0) ? 64'h0F : 64'hF0;
            op = (ch == 0) ? 2'd1 : 2'd2;
            exp_ev(0, base + 3*k, 8'(1 << ch), '0, '0, '0);
            exp_ev(3, base + 3*k + 1, 8'(op), ix, wd, mk);
            exp_ev(1, base + 3*k + 3, 8'(1 << ch), 64'hCAFE, 64'(ch), '0);
        end
        repeat (11) tick;
        c2_valid = '0;
        tick; t2_ready = 1'b0; t2_done = 1'b0; t2_rdata = '0;
        tick;

        // Flush of owner ch1 while in REQ with ready low
        set2(1, 64'h3000, 64'h3333, 64'h33, 2'd3);
        c2_valid = 2'b10;
        exp_ev(0, cyc, 8'b10, '0, '0, '0);
        tick; c2_valid = '0; c2_flush = 2'b10;
        exp_ev(2, cyc + 1, 8'd1, '0, '0, '0);
        tick; c2_flush = '0;
        chk("req_flush_valid_drop", 64'(t2_valid), 64'd0);
        chk("req_flush_rdata_kept", c2_rdata, 64'hCAFE);
        tick; tick;

        // Flush in WAIT, done arrives 2 cycles later while draining
        set2(0, 64'h4000, 64'h4444, 64'h44, 2'd1);
        c2_valid = 2'b01; t2_ready = 1'b1;
        exp_ev(0, cyc, 8'b01, '0, '0, '0);
        exp_ev(3, cyc + 1, 8'd1, 64'h4000, 64'h4444, 64'h44);
        tick; c2_valid = '0;
        tick; t2_ready = 1'b0; c2_flush = 2'b01;
        exp_ev(2, cyc + 1, 8'd1, '0, '0, '0);
        tick; c2_flush = '0;
        set2(1, 64'h5000, 64'h5555, 64'h55, 2'd2);
        c2_valid = 2'b10;
        exp_ev(0, cyc + 2, 8'b10, '0, '0, '0);
        tick; t2_done = 1'b1; t2_rdata = 64'hBAD0;
        tick; t2_done = 1'b0; t2_rdata = '0;
        chk("drain_rdata_kept", c2_rdata, 64'hCAFE);
        tick; c2_valid = '0; t2_ready = 1'b1;
        exp_ev(3, cyc, 8'd2, 64'h5000, 64'h5555, 64'h55);
        tick; t2_ready = 1'b0; t2_done = 1'b1; t2_rdata = 64'h5A5A;
        exp_ev(1, cyc + 1, 8'b10, 64'h5A5A, 64'd1, '0);
        tick; t2_done = 1'b0; t2_rdata = '0;
        tick;

        // Flush and done in the same WAIT cycle; next request granted right after
        set2(0, 64'h6000, 64'h6666, 64'h66, 2'd3);
        c2_valid = 2'b01; t2_ready = 1'b1;
        exp_ev(0, cyc, 8'b01, '0, '0, '0);
        exp_ev(3, cyc + 1, 8'd3, 64'h6000, 64'h6666, 64'h66);
        tick; c2_valid = '0;
        tick; t2_ready = 1'b0; t2_done = 1'b1; c2_flush = 2'b01; t2_rdata = 64'hFFFF;
        set2(1, 64'h7000, 64'h7070, 64'h07, 2'd0);
        c2_valid = 2'b10;
        exp_ev(0, cyc + 1, 8'b10, '0, '0, '0);
        tick; t2_done = 1'b0; c2_flush = '0; t2_rdata = '0;
        chk("flushdone_rdata_kept", c2_rdata, 64'h5A5A);
        tick; c2_valid = '0; t2_ready = 1'b1;
        exp_ev(3, cyc, 8'd0, 64'h7000, 64'h7070, 64'h07);
        tick; t2_ready = 1'b0; t2_done = 1'b1; t2_rdata = 64'h7777;
        exp_ev(1, cyc + 1, 8'b10, 64'h7777, 64'd1, '0);
        tick; t2_done = 1'b0; t2_rdata = '0;
        tick;

        // 4-channel wrap-around: ch2 first moves rr_ptr to 3, then ch3 and ch0
        for (int i = 0; i < 4; i++) begin
            c4_index[i*16 +: 16] = 16'(16'h0100 * (i + 1));
            c4_wdata[i*16 +: 16] = 16'(16'h0011 * (i + 1));
        end
        c4_valid = 4'b0100; t4_ready = 1'b1; t4_done = 1'b1; t4_rdata = 16'h00C4;
        base  = cyc;
        first = STRICT ? 0 : 3;
        exp_ev(4, base, 8'b0100, '0, '0, '0);
        exp_ev(5, base + 3, 8'b0100, 64'h00C4, 64'd2, '0);
        exp_ev(4, base + 3, 8'(1 << first), '0, '0, '0);
        exp_ev(5, base + 6, 8'(1 << first), 64'h00C4, 64'(first), '0);
        exp_ev(4, base + 6, 8'b0001, '0, '0, '0);
        exp_ev(5, base + 9, 8'b0001, 64'h00C4, 64'd0, '0);
        repeat (3) tick;
        c4_valid = 4'b1001;
        repeat (4) tick;
        c4_valid = '0;
        repeat (2) tick;
        t4_ready = 1'b0; t4_done = 1'b0; t4_rdata = '0;
        tick;

        // Reset in the middle of an operation
        c2_valid = 2'b10;
        exp_ev(0, cyc, 8'b10, '0, '0, '0);
        tick; c2_valid = '0;
        chk("prereset_tvalid", 64'(t2_valid), 64'd1);
        chk("prereset_gid", 64'(gid2), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midreset_tvalid", 64'(t2_valid), 64'd0);
        chk("midreset_gid", 64'(gid2), 64'd0);
        chk("midreset_tindex", t2_index, 64'd0);
        chk("midreset_rdata", c2_rdata, 64'd0);
        tick; reset_n = 1'b1;
        tick; tick;

        // Every expected event must have been observed
        chk("left_grant2", 64'(g2_q.size()), 64'd0);
        chk("left_done2", 64'(d2_q.size()), 64'd0);
        chk("left_flush2", 64'(f2_q.size()), 64'd0);
        chk("left_treq2", 64'(t2_q.size()), 64'd0);
        chk("left_grant4", 64'(g4_q.size()), 64'd0);
        chk("left_done4", 64'(d4_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
